pcileech_ft601_dev: RTL and testbench
=====================================

# pcileech_ft601_dev

Synthesizable device-side model of the FT601 in 245 synchronous FIFO mode. It responds to the FPGA-side FT601 controller: it owns RXF_N/TXE_N, drives DATA/BE during reads, and captures DATA/BE during writes. It is used in loopback simulation and on the bench-top interposer. Two internal FIFOs connect the pads to a host-side stream interface: to-FPGA (host→pads) and to-host (pads→host).

## Interface
- FIFO_DEPTH_LOG2, 10, log2 word depth of each internal FIFO (1024 words).
- TXE_HEADROOM, 0, TXE_N goes high when free to-host slots ≤ TXE_HEADROOM.
- clk  in  1  bus clock; all logic single-clock.
- rst  in  1  synchronous, active-high reset.
- FT601_DATA  inout  32  data pads; driven only while drive_q=1, else Z.
- FT601_BE  inout  4  byte enables; 4'b1111 while drive_q=1, else Z.
- FT601_RXF_N  out  1  low = to-FPGA FIFO has data.
- FT601_TXE_N  out  1  low = to-host FIFO can accept.
- FT601_WR_N / FT601_RD_N / FT601_OE_N / FT601_SIWU_N  in  1 each  strobes from the FPGA; SIWU_N is ignored.
- host_tx_data  in  32  word for FPGA, pad byte order, no swapping.
- host_tx_valid / host_tx_ready  in / out  1  push handshake into to-FPGA FIFO.
- host_rx_data / host_rx_be  out  32 / 4  word and BE written by the FPGA.
- host_rx_valid / host_rx_ready  out / in  1  pop handshake from to-host FIFO.
- force_rxf_empty / force_txe_full  in  1  test stall injection; forces RXF_N / TXE_N high.
- ovf_cnt  out  16  saturating count of words dropped (WR_N low while TXE_N high).
- proto_err  out  1  sticky protocol-violation flag.

## Operation
- Bus FSM states: S_IDLE, S_READ, S_WRITE. Update each edge from the sampled strobes:
  - OE_N=0 → S_READ.
  - else WR_N=0 → S_WRITE.
  - else S_IDLE.
- drive_q is registered: drive_q <= ~OE_N.
- While drive_q=1, DATA equals the to-FPGA FIFO head (show-ahead). When the FIFO is empty, DATA holds the last popped word.
- Pop condition: edge with RD_N=0, drive_q=1, and FIFO non-empty. The new head is visible after that edge.
- RD_N low with the FIFO empty: no pop, no error.
- Write capture: edge with WR_N=0 and FT601_TXE_N (current output) low → push {DATA, BE} into the to-host FIFO.
- WR_N low while TXE_N is high → word dropped; ovf_cnt increments, saturating at 16'hFFFF.
- BE≠4'b1111 on a write is stored unchanged; it is not an error.
- proto_err is set by any of:
  - OE_N=0 and WR_N=0 on the same edge;
  - RD_N=0 while drive_q=0;
  - WR_N=0 while drive_q=1 (contention).
- Flags are registered from the post-edge occupancy:
  - RXF_N <= (to-FPGA count_next==0) | force_rxf_empty.
  - TXE_N <= (DEPTH − to-host count_next ≤ TXE_HEADROOM) | force_txe_full.
- Host push and pad pop on the same edge are both honored; count is unchanged.
- Pad push and host pop on the same edge are both honored; count is unchanged.
- Ready/valid:
  - host_tx_ready = to-FPGA FIFO not full.
  - host_rx_valid = to-host FIFO not empty.
- FIFO pointers are FIFO_DEPTH_LOG2 bits and wrap naturally. Counts are FIFO_DEPTH_LOG2+1 bits.

## Timing
- Reset values:
  - RXF_N=1, TXE_N=1, drive_q=0 (DATA/BE = Z).
  - host_tx_ready=0, host_rx_valid=0.
  - ovf_cnt=0, proto_err=0, FSM=S_IDLE.
  - Both FIFOs empty.
- First cycle after reset: TXE_N=0, host_tx_ready=1.
- Reset mid-transfer discards all FIFO contents; drive is released on the reset edge.
- OE_N sampled low at edge n → pads driven from edge n to edge n+1.
- The first pop needs RD_N low at edge n+1 or later.
- The word on DATA before edge k is the word consumed at edge k: zero-latency read, one word per clock.
- Last word popped at edge k → RXF_N high after edge k. This guarantees the controller's one-cycle-delayed RXF_N sample never duplicates a stale word.
- Host push at edge k → RXF_N low after edge k (if it was empty).
- Pad write at edge k → host_rx_valid high after edge k.
- TXE_N rises on the edge whose push reaches the threshold. Subsequent pipelined writes while TXE_N is high are dropped, which exercises the controller's retransmit path.

## Test plan
- Reset, push 0x11223344, 0x55667788, 0xAABBCCDD via host; run controller read → pads deliver the three words in order, exactly once. RXF_N rises after the edge popping 0xAABBCCDD.
- Controller writes 8 words 0..7 with BE=4'b1111 → host_rx_data 0..7 in order, ovf_cnt=0.
- FIFO_DEPTH_LOG2=3: controller bursts 10 words while host_rx_ready=0 → TXE_N high after word 8. Overflow writes are dropped with ovf_cnt incremented. Drain host, let the controller retransmit → host sees 0..9 exactly once.
- Host push and pad pop on the same edge at count=1 → count stays 1, RXF_N stays low, no word lost.
- Pulse force_txe_full for 3 cycles mid-burst → TXE_N high for 3 cycles. After the controller retransmits, all words arrive in order.
- Drive OE_N=0 and WR_N=0 together → proto_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/pcileech_ft601_dev_if.sv
// Host-side stream bundle for the FT601 device model.
// master = host/testbench side, slave = device side.
interface pcileech_ft601_dev_if;
    logic [31:0] host_tx_data;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic [31:0] host_rx_data;
    logic [3:0]  host_rx_be;
    logic        host_rx_valid;
    logic        host_rx_ready;

    modport master (
        output host_tx_data, host_tx_valid, host_rx_ready,
        input  host_tx_ready, host_rx_data, host_rx_be, host_rx_valid
    );

    modport slave (
        input  host_tx_data, host_tx_valid, host_rx_ready,
        output host_tx_ready, host_rx_data, host_rx_be, host_rx_valid
    );
endinterface

// File: rtl/pcileech_ft601_dev.sv
// Device-side model of an FT601 in 245 synchronous FIFO mode.
// to-FPGA FIFO feeds the pads on reads; to-host FIFO captures pad writes.
module pcileech_ft601_dev #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 10,
    parameter int unsigned TXE_HEADROOM    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [31:0]           FT601_DATA,
    inout  wire  [3:0]            FT601_BE,
    output logic                  FT601_RXF_N,
    output logic                  FT601_TXE_N,
    input  logic                  FT601_WR_N,
    input  logic                  FT601_RD_N,
    input  logic                  FT601_OE_N,
    input  logic                  FT601_SIWU_N,
    input  logic                  force_rxf_empty,
    input  logic                  force_txe_full,
    output logic [15:0]           ovf_cnt,
    output logic                  proto_err,
    pcileech_ft601_dev_if.slave   host
);

    localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CntW  = FIFO_DEPTH_LOG2 + 1;

    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CntW-1:0]            cnt_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } bus_state_e;

    bus_state_e state_q, state_d;
    logic       drive_q;

    // to-FPGA FIFO (host -> pads)
    logic [31:0] tf_mem [Depth];
    ptr_t        tf_wr_q, tf_rd_q;
    cnt_t        tf_cnt_q, tf_cnt_d;
    logic        tf_push, tf_pop, tf_empty;
    logic [31:0] last_q;
    logic [31:0] pad_word;

    // to-host FIFO (pads -> host), {data, be}
    logic [35:0] th_mem [Depth];
    ptr_t        th_wr_q, th_rd_q;
    cnt_t        th_cnt_q, th_cnt_d;
    logic        th_push, th_pop, th_drop, th_full;

    logic tx_ready_q;
    logic txe_full_d;
    logic unused_siwu;

    assign unused_siwu = FT601_SIWU_N;

    // Drive tracks last sampled OE_N, which is exactly the READ state.
    assign drive_q = (state_q == S_READ);

    assign tf_empty = (tf_cnt_q == '0);
    assign th_full  = (th_cnt_q == cnt_t'(Depth));

    assign tf_push = host.host_tx_valid & tx_ready_q;
    assign tf_pop  = ~FT601_RD_N & drive_q & ~tf_empty;
    // Capture qualifies on the TXE_N the controller currently sees.
    assign th_push = ~FT601_WR_N & ~FT601_TXE_N & ~th_full;
    assign th_drop = ~FT601_WR_N & FT601_TXE_N;
    assign th_pop  = host.host_rx_valid & host.host_rx_ready;

    // Show-ahead head; hold the last popped word once the FIFO runs dry.
    assign pad_word   = tf_empty ? last_q : tf_mem[tf_rd_q];
    assign FT601_DATA = drive_q ? pad_word : 32'bz;
    assign FT601_BE   = drive_q ? 4'b1111 : 4'bz;

    assign host.host_tx_ready = tx_ready_q;
    assign host.host_rx_valid = (th_cnt_q != '0);
    assign host.host_rx_data  = th_mem[th_rd_q][35:4];
    assign host.host_rx_be    = th_mem[th_rd_q][3:0];

    assign txe_full_d = (Depth - 32'(th_cnt_d)) <= TXE_HEADROOM;

    // Bus state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next bus state and post-edge FIFO occupancies.
    always_comb begin
        state_d  = S_IDLE;
        tf_cnt_d = tf_cnt_q;
        th_cnt_d = th_cnt_q;
        if (!FT601_OE_N)      state_d = S_READ;
        else if (!FT601_WR_N) state_d = S_WRITE;
        if (tf_push && !tf_pop)      tf_cnt_d = tf_cnt_q + cnt_t'(1);
        else if (!tf_push && tf_pop) tf_cnt_d = tf_cnt_q - cnt_t'(1);
        if (th_push && !th_pop)      th_cnt_d = th_cnt_q + cnt_t'(1);
        else if (!th_push && th_pop) th_cnt_d = th_cnt_q - cnt_t'(1);
    end

    // FIFO storage; contents are don't-care until pointers cover them.
    always_ff @(posedge clk) begin
        if (tf_push) tf_mem[tf_wr_q] <= host.host_tx_data;
        if (th_push) th_mem[th_wr_q] <= {FT601_DATA, FT601_BE};
    end

    // Pointers, counts and the held read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            tf_wr_q  <= '0;
            tf_rd_q  <= '0;
            tf_cnt_q <= '0;
            th_wr_q  <= '0;
            th_rd_q  <= '0;
            th_cnt_q <= '0;
            last_q   <= '0;
        end else begin
            tf_cnt_q <= tf_cnt_d;
            th_cnt_q <= th_cnt_d;
            if (tf_push) tf_wr_q <= tf_wr_q + ptr_t'(1);
            if (tf_pop) begin
                tf_rd_q <= tf_rd_q + ptr_t'(1);
                last_q  <= tf_mem[tf_rd_q];
            end
            if (th_push) th_wr_q <= th_wr_q + ptr_t'(1);
            if (th_pop)  th_rd_q <= th_rd_q + ptr_t'(1);
        end
    end

    // Pad flags and host ready, registered from post-edge occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            FT601_RXF_N <= 1'b1;
            FT601_TXE_N <= 1'b1;
            tx_ready_q  <= 1'b0;
        end else begin
            FT601_RXF_N <= (tf_cnt_d == '0) | force_rxf_empty;
            FT601_TXE_N <= txe_full_d | force_txe_full;
            tx_ready_q  <= (tf_cnt_d != cnt_t'(Depth));
        end
    end

    // Overflow counter and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (th_drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            if ((!FT601_OE_N && !FT601_WR_N) || (!FT601_RD_N && !drive_q) ||
                (!FT601_WR_N && drive_q)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcileech_ft601_dev.sv
// Directed bench for pcileech_ft601_dev with an 8-word FIFO configuration.
module tb_pcileech_ft601_dev;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [31:0] pad_data;
    wire  [3:0]  pad_be;
    logic [31:0] tb_data = '0;
    logic [3:0]  tb_be   = 4'hF;
    logic        tb_drv  = 1'b0;
    logic        rxf_n, txe_n;
    logic        wr_n = 1'b1, rd_n = 1'b1, oe_n = 1'b1, siwu_n = 1'b1;
    logic        f_rxf = 1'b0, f_txe = 1'b0;
    logic [15:0] ovf;
    logic        perr;
    int          checks = 0;
    int          errors = 0;

    assign pad_data = tb_drv ? tb_data : 32'bz;
    assign pad_be   = tb_drv ? tb_be : 4'bz;

    pcileech_ft601_dev_if hif ();

    pcileech_ft601_dev #(
        .FIFO_DEPTH_LOG2 (3),
        .TXE_HEADROOM    (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .FT601_DATA      (pad_data),
        .FT601_BE        (pad_be),
        .FT601_RXF_N     (rxf_n),
        .FT601_TXE_N     (txe_n),
        .FT601_WR_N      (wr_n),
        .FT601_RD_N      (rd_n),
        .FT601_OE_N      (oe_n),
        .FT601_SIWU_N    (siwu_n),
        .force_rxf_empty (f_rxf),
        .force_txe_full  (f_txe),
        .ovf_cnt         (ovf),
        .proto_err       (perr),
        .host            (hif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input logic [31:0] base, input int n, input logic [3:0] be);
        hif.host_rx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("rx_valid", hif.host_rx_valid, 1'b1);
            chk("rx_data", hif.host_rx_data, base + 32'(i));
            chk("rx_be", hif.host_rx_be, be);
            tick();
        end
        hif.host_rx_ready = 1'b0;
        chk("rx_empty", hif.host_rx_valid, 1'b0);
    endtask

    initial begin
        int idx, cyc, hi;
        logic was;
        hif.host_tx_data  = '0;
        hif.host_tx_valid = 1'b0;
        hif.host_rx_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_rxf", rxf_n, 1'b1);
        chk("rst_txe", txe_n, 1'b1);
        chk("rst_drive", dut.drive_q, 1'b0);
        chk("rst_ready", hif.host_tx_ready, 1'b0);
        chk("rst_valid", hif.host_rx_valid, 1'b0);
        chk("rst_ovf", ovf, 16'd0);
        chk("rst_perr", perr, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst_txe", txe_n, 1'b0);
        chk("post_rst_ready", hif.host_tx_ready, 1'b1);
        chk("post_rst_rxf", rxf_n, 1'b1);

        // Host pushes three words, controller reads them back
        hif.host_tx_valid = 1'b1;
        hif.host_tx_data  = 32'h11223344; tick();
        chk("push_rxf", rxf_n, 1'b0);
        hif.host_tx_data  = 32'h55667788; tick();
        hif.host_tx_data  = 32'hAABBCCDD; tick();
        hif.host_tx_valid = 1'b0;
        oe_n = 1'b0; tick();
        chk("rd_drive", dut.drive_q, 1'b1);
        chk("rd_w0", pad_data, 32'h11223344);
        chk("rd_be", pad_be, 4'hF);
        rd_n = 1'b0; tick();
        chk("rd_w1", pad_data, 32'h55667788);
        chk("rd_rxf1", rxf_n, 1'b0);
        tick();
        chk("rd_w2", pad_data, 32'hAABBCCDD);
        chk("rd_rxf2", rxf_n, 1'b0);
        tick();
        chk("rd_last_rxf", rxf_n, 1'b1);
        chk("rd_hold", pad_data, 32'hAABBCCDD);
        tick();
        chk("rd_empty_hold", pad_data, 32'hAABBCCDD);
        chk("rd_empty_rxf", rxf_n, 1'b1);
        chk("rd_perr", perr, 1'b0);
        rd_n = 1'b1; oe_n = 1'b1; tick();
        chk("rd_release", dut.drive_q, 1'b0);

        // Controller writes 0..7
        tb_drv = 1'b1; tb_be = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tb_data = 32'(i); wr_n = 1'b0; tick();
        end
        wr_n = 1'b1; tb_drv = 1'b0;
        chk("wr8_txe", txe_n, 1'b1);
        chk("wr8_ovf", ovf, 16'd0);
        drain(32'd0, 8, 4'hF);
        chk("wr8_txe_low", txe_n, 1'b0);

        // Overflow burst of 10 then retransmit of the two dropped words
        tb_drv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tb_data = 32'd100 + 32'(i); wr_n = 1'b0; tick();
            if (i == 7) chk("ovf_txe_at8", txe_n, 1'b1);
        end
        wr_n = 1'b1; tb_drv = 1'b0;
        chk("ovf_cnt2", ovf, 16'd2);
        drain(32'd100, 8, 4'hF);
        tb_drv = 1'b1; tb_be = 4'h3;
        tb_data = 32'd108; wr_n = 1'b0; tick();
        tb_data = 32'd109; tick();
        wr_n = 1'b1; tb_drv = 1'b0;
        drain(32'd108, 2, 4'h3);
        chk("ovf_cnt2_hold", ovf, 16'd2);
        tb_be = 4'hF;

        // Same-edge host push and pad pop at count 1
        hif.host_tx_valid = 1'b1; hif.host_tx_data = 32'hCAFE0001; tick();
        hif.host_tx_valid = 1'b0;
        oe_n = 1'b0; tick();
        chk("same_head", pad_data, 32'hCAFE0001);
        hif.host_tx_valid = 1'b1; hif.host_tx_data = 32'hCAFE0002; rd_n = 1'b0; tick();
        hif.host_tx_valid = 1'b0;
        chk("same_rxf", rxf_n, 1'b0);
        chk("same_next", pad_data, 32'hCAFE0002);
        tick();
        chk("same_drain_rxf", rxf_n, 1'b1);
        rd_n = 1'b1; oe_n = 1'b1; tick();
        chk("same_perr", perr, 1'b0);

        // force_txe_full pulse with a retransmitting controller
        idx = 0; cyc = 0; hi = 0;
        tb_drv = 1'b1;
        while (idx < 6 && cyc < 40) begin
            f_txe   = (cyc >= 2 && cyc < 5);
            tb_data = 32'd200 + 32'(idx);
            wr_n    = 1'b0;
            was     = txe_n;
            if (txe_n) hi++;
            tick();
            if (!was) idx++;
            cyc++;
        end
        f_txe = 1'b0; wr_n = 1'b1; tb_drv = 1'b0;
        chk("force_done", 36'(idx), 36'd6);
        chk("force_hi_cycles", 36'(hi), 36'd3);
        chk("force_ovf", ovf, 16'd5);
        drain(32'd200, 6, 4'hF);

        // Protocol violation is sticky
        oe_n = 1'b0; wr_n = 1'b0; tick();
        oe_n = 1'b1; wr_n = 1'b1;
        chk("perr_set", perr, 1'b1);
        tick(); tick();
        chk("perr_sticky", perr, 1'b1);

        // Reset mid-transfer
        hif.host_tx_valid = 1'b1; hif.host_tx_data = 32'h0BAD0BAD; tick();
        hif.host_tx_valid = 1'b0;
        oe_n = 1'b0; tick();
        rst = 1'b1; tick();
        chk("mid_rst_drive", dut.drive_q, 1'b0);
        chk("mid_rst_perr", perr, 1'b0);
        chk("mid_rst_rxf", rxf_n, 1'b1);
        chk("mid_rst_valid", hif.host_rx_valid, 1'b0);
        oe_n = 1'b1; rst = 1'b0; tick();
        chk("mid_rst_rxf_empty", rxf_n, 1'b1);
        chk("mid_rst_txe", txe_n, 1'b0);

        // RD_N low while not driving
        rd_n = 1'b0; tick();
        rd_n = 1'b1;
        chk("perr_rd_undriven", perr, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
